// File: rtl/regfile_mp_sb_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file with busy scoreboard:
//   XLEN_DEFAULT     default data width
//   NUM_REGS_DEFAULT default register count
//   reg_addr_t       register address type for the default register count
//   ZERO_REG_IDX     index of the hardwired-zero register
//   PAR_MAX_W        widest data word the parity helper accepts
//   even_parity()    even-parity bit of a (zero-extended) data word
// Optional feature macro used by the design: REGFILE_PARITY_EN
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int ZERO_REG_IDX     = 0;
  localparam int PAR_MAX_W        = 64;

  typedef logic [$clog2(NUM_REGS_DEFAULT)-1:0] reg_addr_t;

  // Even parity: the returned bit makes the total number of ones even.
  // Zero-extension does not change the result, so narrower words are
  // simply widened by the caller.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb_if
// Bundle of the register-file access signals between issue/writeback logic
// (master) and the register file (slave).
//   wr_en/wr_addr/wr_data   write ports (master -> slave)
//   rd_addr                 read addresses (master -> slave)
//   rd_data/rd_busy/rd_perr read results (slave -> master, combinational)
//   alloc_en/alloc_addr     mark a destination register busy
//   flush                   clear all busy bits
//   busy_cnt                registered count of busy registers
// -----------------------------------------------------------------------------
interface regfile_mp_sb_if #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_WR-1:0]              wr_en;
  logic [NUM_WR-1:0][AW-1:0]      wr_addr;
  logic [NUM_WR-1:0][XLEN-1:0]    wr_data;
  logic [NUM_RD-1:0][AW-1:0]      rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0]    rd_data;
  logic [NUM_RD-1:0]              rd_busy;
  logic [NUM_RD-1:0]              rd_perr;
  logic                           alloc_en;
  logic [AW-1:0]                  alloc_addr;
  logic                           flush;
  logic [AW:0]                    busy_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, alloc_en, alloc_addr, flush,
    input  rd_data, rd_busy, rd_perr, busy_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, alloc_en, alloc_addr, flush,
    output rd_data, rd_busy, rd_perr, busy_cnt
  );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register busy bits for the register file plus a registered busy count.
// Priority per register: flush clears, else alloc sets, else a writeback to
// that register clears, else hold.
//   clk, rst        clock, synchronous active-high reset
//   i_wr_en/addr    writeback ports (clear busy)
//   i_alloc_en/addr destination allocation (set busy)
//   i_flush         clear every busy bit
//   o_busy          current busy vector
//   o_busy_cnt      popcount of o_busy (registered alongside it)
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_WR-1:0]         i_wr_en,
  input  logic [NUM_WR-1:0][AW-1:0] i_wr_addr,
  input  logic                      i_alloc_en,
  input  logic [AW-1:0]             i_alloc_addr,
  input  logic                      i_flush,
  output logic [NUM_REGS-1:0]       o_busy,
  output logic [AW:0]               o_busy_cnt
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;
  logic [AW:0]         r_busy_cnt;
  logic [AW:0]         w_cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
      if ((ZERO_REG != 0) && (gi == ZERO_REG_IDX)) begin : g_zero
        // The zero register can never have a pending producer.
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic w_set;
        logic w_clr;
        logic w_next;

        always_comb begin
          w_clr = 1'b0;
          for (int p = 0; p < NUM_WR; p++) begin
            if (i_wr_en[p] && (i_wr_addr[p] == AW'(gi))) w_clr = 1'b1;
          end
        end

        assign w_set = i_alloc_en && (i_alloc_addr == AW'(gi));

        // Alloc outranks writeback: a new producer was issued for this reg.
        always_comb begin
          w_next = r_busy[gi];
          if (i_flush)    w_next = 1'b0;
          else if (w_set) w_next = 1'b1;
          else if (w_clr) w_next = 1'b0;
        end

        assign w_busy_next[gi] = w_next;
      end
    end
  endgenerate

  // Count from the next-state vector so the count register lands on the
  // same edge as the busy bits it describes.
  always_comb begin
    w_cnt_next = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_cnt_next = w_cnt_next + (AW+1)'(w_busy_next[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_cnt_next;
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_cnt = r_busy_cnt;

endmodule

// File: rtl/regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// regfile_mp_sb
// Multi-port integer register file with same-cycle write bypass and a busy
// scoreboard for operands whose producer has issued but not written back.
//   clk     clock, all state updates on posedge
//   rst     synchronous active-high reset
//   io_bus  regfile_mp_sb_if.slave: write ports, async read ports with
//           busy/parity flags, alloc/flush controls, registered busy_cnt
// Optional feature: define REGFILE_PARITY_EN to store one even-parity bit per
// register and flag mismatches on storage reads via rd_perr. Without it
// rd_perr is tied low; the port list is the same either way.
// -----------------------------------------------------------------------------
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = XLEN_DEFAULT,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  regfile_mp_sb_if.slave   io_bus
);

  logic [XLEN-1:0]     r_mem [NUM_REGS];
  logic [NUM_WR-1:0]   w_wr_keep;
  logic [NUM_REGS-1:0] w_busy;
  logic [AW:0]         w_busy_cnt;

  genvar gi;

  // A write takes effect unless it targets the hardwired zero register.
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
      assign w_wr_keep[gi] = io_bus.wr_en[gi] &&
                             !((ZERO_REG != 0) &&
                               (io_bus.wr_addr[gi] == AW'(ZERO_REG_IDX)));
    end
  endgenerate

  // Ports are visited in ascending order so the highest index wins a
  // same-address conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_mem[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (w_wr_keep[p]) r_mem[io_bus.wr_addr[p]] <= io_bus.wr_data[p];
      end
    end
  end

`ifdef REGFILE_PARITY_EN
  logic [NUM_REGS-1:0] r_parity;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_parity <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (w_wr_keep[p])
          r_parity[io_bus.wr_addr[p]] <= even_parity(PAR_MAX_W'(io_bus.wr_data[p]));
      end
    end
  end
`endif

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (io_bus.wr_en),
    .i_wr_addr    (io_bus.wr_addr),
    .i_alloc_en   (io_bus.alloc_en),
    .i_alloc_addr (io_bus.alloc_addr),
    .i_flush      (io_bus.flush),
    .o_busy       (w_busy),
    .o_busy_cnt   (w_busy_cnt)
  );

  assign io_bus.busy_cnt = w_busy_cnt;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic            w_zero;
      logic            w_hit;
      logic [XLEN-1:0] w_byp;
      logic [XLEN-1:0] w_data;
      logic            w_busy_rd;
      logic            w_perr;

      assign w_addr = io_bus.rd_addr[gi];
      assign w_zero = (ZERO_REG != 0) && (w_addr == AW'(ZERO_REG_IDX));

      // Bypass: highest-index enabled port writing this address this cycle.
      always_comb begin
        w_hit = 1'b0;
        w_byp = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          if (io_bus.wr_en[p] && (io_bus.wr_addr[p] == w_addr)) begin
            w_hit = 1'b1;
            w_byp = io_bus.wr_data[p];
          end
        end
      end

      always_comb begin
        w_data = '0;
        if (rst || w_zero) w_data = '0;
        else if (w_hit)    w_data = w_byp;
        else               w_data = r_mem[w_addr];
      end

      // A writeback landing this cycle resolves the pending operand.
      assign w_busy_rd = !rst && !w_zero && w_busy[w_addr] && !w_hit;

`ifdef REGFILE_PARITY_EN
      assign w_perr = !rst && !w_zero && !w_hit &&
                      (r_parity[w_addr] != even_parity(PAR_MAX_W'(r_mem[w_addr])));
`else
      assign w_perr = 1'b0;
`endif

      assign io_bus.rd_data[gi] = w_data;
      assign io_bus.rd_busy[gi] = w_busy_rd;
      assign io_bus.rd_perr[gi] = w_perr;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp_sb.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp_sb
// Directed bench for regfile_mp_sb (2 read / 2 write ports, zero register on).
// Stimulus drives the bus shortly after each rising edge and queues the
// responses expected in that cycle; a monitor drains the queue on the falling
// edge and compares against the live outputs.
// Parity vectors are included when REGFILE_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_regfile_mp_sb;
  import regfile_pkg::*;

  localparam int NR  = 32;
  localparam int XL  = 32;
  localparam int NRD = 2;
  localparam int NWR = 2;
  localparam int AW  = 5;

  localparam int K_DATA = 0;
  localparam int K_BUSY = 1;
  localparam int K_PERR = 2;
  localparam int K_CNT  = 3;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  regfile_mp_sb_if #(.NUM_REGS(NR), .XLEN(XL), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

  regfile_mp_sb #(
    .NUM_REGS (NR),
    .XLEN     (XL),
    .NUM_RD   (NRD),
    .NUM_WR   (NWR),
    .ZERO_REG (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    string       name;
    int          kind;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input string name, input int kind, input int port, input logic [31:0] exp);
    exp_t t;
    t.name = name;
    t.kind = kind;
    t.port = port;
    t.exp  = exp;
    q.push_back(t);
  endtask

  task automatic exp_rd(input string name, input int port, input logic [31:0] data,
                        input logic busy, input logic perr);
    push({name, "_data"}, K_DATA, port, data);
    push({name, "_busy"}, K_BUSY, port, 32'(busy));
    push({name, "_perr"}, K_PERR, port, 32'(perr));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.wr_en    = '0;
    bus.alloc_en = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] data);
    bus.wr_en[port]   = 1'b1;
    bus.wr_addr[port] = AW'(addr);
    bus.wr_data[port] = data;
  endtask

  always @(negedge clk) begin
    exp_t        t;
    logic [31:0] act;
    while (q.size() > 0) begin
      t = q.pop_front();
      case (t.kind)
        K_DATA:  act = bus.rd_data[t.port];
        K_BUSY:  act = 32'(bus.rd_busy[t.port]);
        K_PERR:  act = 32'(bus.rd_perr[t.port]);
        default: act = 32'(bus.busy_cnt);
      endcase
      n_checks++;
      if (act !== t.exp) begin
        n_fail++;
        $display("[%0t] FAIL %s port%0d: got %h expected %h", $time, t.name, t.port, act, t.exp);
      end else begin
        $display("[%0t] ok   %s port%0d: %h", $time, t.name, t.port, act);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

`ifdef REGFILE_PARITY_EN
  logic [NR-1:0] par_snap;
`endif

  initial begin
    rst             = 1'b1;
    bus.wr_en       = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.rd_addr     = '0;
    bus.alloc_en    = 1'b0;
    bus.alloc_addr  = '0;
    bus.flush       = 1'b0;

    step();
    bus.rd_addr[0] = AW'(3);
    bus.rd_addr[1] = AW'(17);
    exp_rd("rst_rd0", 0, 32'h0, 1'b0, 1'b0);
    exp_rd("rst_rd1", 1, 32'h0, 1'b0, 1'b0);
    push("rst_cnt", K_CNT, 0, 32'd0);
    step();
    rst = 1'b0;

    for (int a = 0; a < NR; a++) begin
      step();
      bus.rd_addr[0] = AW'(a);
      bus.rd_addr[1] = AW'(NR - 1 - a);
      exp_rd("init_rd0", 0, 32'h0, 1'b0, 1'b0);
      push("init_rd1_data", K_DATA, 1, 32'h0);
      push("init_cnt", K_CNT, 0, 32'd0);
    end

    step();
    wr(0, 5, 32'hDEADBEEF);
    bus.rd_addr[0] = AW'(5);
    exp_rd("byp5", 0, 32'hDEADBEEF, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.rd_data[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[%0t] FAIL byp5_direct: got %h expected deadbeef", $time, bus.rd_data[0]);
    end else begin
      $display("[%0t] ok   byp5_direct: %h", $time, bus.rd_data[0]);
    end
    step();
    bus.rd_addr[0] = AW'(5);
    exp_rd("store5", 0, 32'hDEADBEEF, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (bus.rd_data[0] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("[%0t] FAIL store5_direct: got %h expected deadbeef", $time, bus.rd_data[0]);
    end else begin
      $display("[%0t] ok   store5_direct: %h", $time, bus.rd_data[0]);
    end

    step();
    wr(0, 0, 32'h1234);
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = AW'(0);
    bus.rd_addr[0] = AW'(0);
    exp_rd("zero_wr", 0, 32'h0, 1'b0, 1'b0);
    step();
    bus.rd_addr[0] = AW'(0);
    exp_rd("zero_rd", 0, 32'h0, 1'b0, 1'b0);
    push("zero_cnt", K_CNT, 0, 32'd0);
    #1;
    n_checks++;
    if (bus.rd_data[0] !== 32'h0 || bus.rd_busy[0] !== 1'b0) begin
      n_fail++;
      $display("[%0t] FAIL zero_direct: data %h busy %b", $time, bus.rd_data[0], bus.rd_busy[0]);
    end else begin
      $display("[%0t] ok   zero_direct: data %h busy %b", $time, bus.rd_data[0], bus.rd_busy[0]);
    end

    step();
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = AW'(7);
    bus.rd_addr[0] = AW'(7);
    push("alloc7_same_busy", K_BUSY, 0, 32'd0);
    step();
    bus.rd_addr[0] = AW'(7);
    push("alloc7_busy", K_BUSY, 0, 32'd1);
    push("alloc7_cnt", K_CNT, 0, 32'd1);
    #1;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b1 || bus.busy_cnt !== 6'd1) begin
      n_fail++;
      $display("[%0t] FAIL alloc7_direct: busy %b cnt %0d", $time, bus.rd_busy[0], bus.busy_cnt);
    end else begin
      $display("[%0t] ok   alloc7_direct: busy %b cnt %0d", $time, bus.rd_busy[0], bus.busy_cnt);
    end
    step();
    wr(0, 7, 32'h55);
    bus.rd_addr[0] = AW'(7);
    exp_rd("wb7", 0, 32'h55, 1'b0, 1'b0);
    push("wb7_cnt", K_CNT, 0, 32'd1);
    #1;
    n_checks++;
    if (bus.rd_busy[0] !== 1'b0 || bus.rd_data[0] !== 32'h55) begin
      n_fail++;
      $display("[%0t] FAIL wb7_direct: data %h busy %b", $time, bus.rd_data[0], bus.rd_busy[0]);
    end else begin
      $display("[%0t] ok   wb7_direct: data %h busy %b", $time, bus.rd_data[0], bus.rd_busy[0]);
    end
    step();
    bus.rd_addr[0] = AW'(7);
    exp_rd("after_wb7", 0, 32'h55, 1'b0, 1'b0);
    push("after_wb7_cnt", K_CNT, 0, 32'd0);

    step();
    wr(0, 9, 32'hA);
    wr(1, 9, 32'hB);
    bus.rd_addr[0] = AW'(9);
    bus.rd_addr[1] = AW'(5);
    push("conf9_byp", K_DATA, 0, 32'hB);
    push("rd1_5", K_DATA, 1, 32'hDEADBEEF);
    step();
    bus.rd_addr[0] = AW'(9);
    bus.rd_addr[1] = AW'(7);
    push("conf9_store", K_DATA, 0, 32'hB);
    push("rd1_7", K_DATA, 1, 32'h55);
    #1;
    n_checks++;
    if (bus.rd_data[0] !== 32'hB) begin
      n_fail++;
      $display("[%0t] FAIL conf9_direct: got %h expected 0000000b", $time, bus.rd_data[0]);
    end else begin
      $display("[%0t] ok   conf9_direct: %h", $time, bus.rd_data[0]);
    end

    step();
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = AW'(9);
    wr(0, 9, 32'hC);
    bus.rd_addr[0] = AW'(9);
    exp_rd("alloc_wb9", 0, 32'hC, 1'b0, 1'b0);
    push("alloc_wb9_cnt", K_CNT, 0, 32'd0);
    step();
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = AW'(12);
    bus.rd_addr[0] = AW'(9);
    exp_rd("busy9", 0, 32'hC, 1'b1, 1'b0);
    push("busy9_cnt", K_CNT, 0, 32'd1);
    step();
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = AW'(9);
    bus.rd_addr[0] = AW'(9);
    bus.rd_addr[1] = AW'(12);
    push("busy9b", K_BUSY, 0, 32'd1);
    push("busy12", K_BUSY, 1, 32'd1);
    push("two_cnt", K_CNT, 0, 32'd2);
    step();
    push("realloc_busy9", K_BUSY, 0, 32'd1);
    push("realloc_cnt", K_CNT, 0, 32'd2);
    bus.flush      = 1'b1;
    bus.alloc_en   = 1'b1;
    bus.alloc_addr = AW'(3);
    step();
    bus.rd_addr[0] = AW'(3);
    bus.rd_addr[1] = AW'(12);
    push("flush_busy3", K_BUSY, 0, 32'd0);
    push("flush_busy12", K_BUSY, 1, 32'd0);
    push("flush_cnt", K_CNT, 0, 32'd0);
    #1;
    n_checks++;
    if (bus.busy_cnt !== 6'd0 || bus.rd_busy[1] !== 1'b0) begin
      n_fail++;
      $display("[%0t] FAIL flush_direct: cnt %0d busy12 %b", $time, bus.busy_cnt, bus.rd_busy[1]);
    end else begin
      $display("[%0t] ok   flush_direct: cnt %0d busy12 %b", $time, bus.busy_cnt, bus.rd_busy[1]);
    end
    step();
    bus.rd_addr[0] = AW'(9);
    exp_rd("flush_rd9", 0, 32'hC, 1'b0, 1'b0);

`ifdef REGFILE_PARITY_EN
    step();
    wr(0, 4, 32'h1);
    step();
    par_snap = dut.r_parity;
    force dut.r_parity = par_snap ^ (NR'(1) << 4);
    bus.rd_addr[0] = AW'(4);
    bus.rd_addr[1] = AW'(5);
    exp_rd("perr4", 0, 32'h1, 1'b0, 1'b1);
    push("perr5", K_PERR, 1, 32'd0);
    step();
    wr(0, 4, 32'h1);
    bus.rd_addr[0] = AW'(4);
    exp_rd("perr4_byp", 0, 32'h1, 1'b0, 1'b0);
    step();
    release dut.r_parity;
`endif

    step();
    step();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
